// File: rtl/minibus_pkg.sv
// Shared Mini-Bus types: bus widths, access width encoding, request/response bundles.
package minibus_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } minibus_width_t;

  typedef struct packed {
    logic                  wen;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] addr;
    minibus_width_t        width;
    logic [DATA_WIDTH-1:0] wdata;
  } minibus_req_t;

  typedef struct packed {
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } minibus_res_t;

  // True when the access cannot be issued on the bus (unaligned or undefined width).
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    logic bad;
    case (width)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/minibus_master_if.sv
// Mini-Bus link between one master and its slaves.
interface minibus_master_if (
  input logic clk,
  input logic nrst
);
  import minibus_pkg::*;

  minibus_req_t req;
  minibus_res_t res;

  modport master (input clk, input nrst, output req, input res);
  modport slave  (input clk, input nrst, input req, output res);

endinterface

// File: rtl/minibus_rdata_align.sv
// Picks the addressed byte/half-word out of a slave word and extends it.
module minibus_rdata_align
  import minibus_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            addr_lo,
  input  minibus_width_t        width,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] byte_lane;
  logic [DATA_WIDTH-1:0] half_lane;

  // Shift the addressed lane down to bit 0, then sign/zero extend by width.
  always_comb begin
    byte_lane = word >> {addr_lo, 3'b000};
    half_lane = word >> {addr_lo[1], 4'b0000};
    case (width)
      BYTE:    data = {{(DATA_WIDTH-8){~is_unsigned & byte_lane[7]}}, byte_lane[7:0]};
      HALF:    data = {{(DATA_WIDTH-16){~is_unsigned & half_lane[15]}}, half_lane[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/minibus_master_ctrl.sv
// Single-outstanding Mini-Bus master: core load/store -> bus transaction -> response.
module minibus_master_ctrl
  import minibus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_wen,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  minibus_width_t        cpu_width,
  input  logic                  cpu_unsigned,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  minibus_master_if.master      _masterif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_TURN = 2'b10
  } state_t;

  // A zero timeout would give a zero-width counter; keep one bit and never fire.
  localparam int unsigned   CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  unsigned_q, unsigned_d;
  minibus_req_t          req_q, req_d;
  logic                  ready_d, resp_valid_d, err_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] aligned;

  logic accept, misalign, ack_hit, timeout_hit;

  assign accept      = cpu_req_ready & cpu_req_valid;
  assign misalign    = is_misaligned(cpu_width, cpu_addr[1:0]);
  assign ack_hit     = (state_q == ST_BUS) & _masterif.res.ack;
  assign timeout_hit = TO_EN & (state_q == ST_BUS) & ~_masterif.res.ack & (cnt_q == CNT_MAX);

  assign _masterif.req = req_q;

  minibus_rdata_align u_align (
    .word        (_masterif.res.rdata),
    .addr_lo     (req_q.addr[1:0]),
    .width       (req_q.width),
    .is_unsigned (unsigned_q),
    .data        (aligned)
  );

  // State and all registered outputs; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      unsigned_q     <= 1'b0;
      req_q          <= '0;
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      unsigned_q     <= unsigned_d;
      req_q          <= req_d;
      cpu_req_ready  <= ready_d;
      cpu_resp_valid <= resp_valid_d;
      cpu_rdata      <= rdata_d;
      cpu_err        <= err_d;
    end
  end

  // Next state: misaligned requests skip the bus; TURN always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = misalign ? ST_TURN : ST_BUS;
      ST_BUS:  if (ack_hit || timeout_hit) state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, request bundle and timeout counter.
  always_comb begin
    req_d        = req_q;
    cnt_d        = cnt_q;
    unsigned_d   = unsigned_q;
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    rdata_d      = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          unsigned_d = cpu_unsigned;
          if (misalign) begin
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
          end else begin
            req_d.wen   = cpu_wen;
            req_d.ren   = ~cpu_wen;
            req_d.addr  = cpu_addr;
            req_d.width = cpu_width;
            req_d.wdata = cpu_wdata;
          end
        end
      end
      ST_BUS: begin
        if (ack_hit) begin
          req_d.wen    = 1'b0;
          req_d.ren    = 1'b0;
          resp_valid_d = 1'b1;
          err_d        = _masterif.res.err;
          rdata_d      = (req_q.wen || _masterif.res.err) ? '0 : aligned;
        end else if (timeout_hit) begin
          req_d        = '0;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minibus_master_ctrl.sv
// Randomized bench for minibus_master_ctrl with a register-array slave and a behavioural model.
module tb_minibus_master_ctrl;
  import minibus_pkg::*;

  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           cpu_req_valid = 1'b0;
  logic           cpu_req_ready;
  logic           cpu_wen = 1'b0;
  logic [31:0]    cpu_addr = '0;
  minibus_width_t cpu_width = BYTE;
  logic           cpu_unsigned = 1'b0;
  logic [31:0]    cpu_wdata = '0;
  logic           cpu_resp_valid;
  logic [31:0]    cpu_rdata;
  logic           cpu_err;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned slv_delay = 0;
  int unsigned wcnt;

  logic [31:0] smem [64];   // slave storage
  logic [31:0] mmem [64];   // model's view of the same storage

  always #5 clk = ~clk;

  minibus_master_if mif (.clk(clk), .nrst(nrst));

  minibus_master_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_wen        (cpu_wen),
    .cpu_addr       (cpu_addr),
    .cpu_width      (cpu_width),
    .cpu_unsigned   (cpu_unsigned),
    .cpu_wdata      (cpu_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_err        (cpu_err),
    ._masterif      (mif)
  );

  // Slave: 0x000-0x0FF register array, 0x100-0x1FF error responder, rest unselected.
  // Ack is registered after slv_delay wait cycles and stays high while the request does.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mif.res <= '0;
      wcnt    <= 0;
    end else begin
      mif.res.ack   <= 1'b0;
      mif.res.err   <= 1'b0;
      mif.res.rdata <= $urandom;
      if ((mif.req.wen || mif.req.ren) && mif.req.addr < 32'h200) begin
        if (wcnt >= slv_delay) begin
          mif.res.ack <= 1'b1;
          if (mif.req.addr >= 32'h100) begin
            mif.res.err   <= 1'b1;
            mif.res.rdata <= 32'hA5A5A5A5;
          end else if (mif.req.ren) begin
            mif.res.rdata <= smem[mif.req.addr[7:2]];
          end else begin
            case (mif.req.width)
              BYTE:    smem[mif.req.addr[7:2]][mif.req.addr[1:0]*8 +: 8] <= mif.req.wdata[7:0];
              HALF:    smem[mif.req.addr[7:2]][mif.req.addr[1]*16 +: 16] <= mif.req.wdata[15:0];
              default: smem[mif.req.addr[7:2]] <= mif.req.wdata;
            endcase
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One core access; expectations come from address-map and lane arithmetic.
  task automatic do_access(input logic wen, input logic [31:0] addr, input logic [1:0] w,
                           input logic uns, input logic [31:0] wdata, output logic [31:0] rd_o);
    int unsigned size, lo, idx, sh, exp_lat, busy;
    logic [31:0] v, mask, exp_rd;
    logic misal, in_mem, in_err, no_ack, exp_err, got, ready_seen;

    size    = 1 << w;
    misal   = (w == 2'd3) || (addr % size != 0);
    in_mem  = addr < 32'h100;
    in_err  = !in_mem && addr < 32'h200;
    no_ack  = !in_mem && !in_err;
    exp_err = misal || !in_mem;
    exp_lat = misal ? 0 : (no_ack ? TO + 1 : 2 + slv_delay);
    idx     = (addr / 4) % 64;
    lo      = addr % 4;
    exp_rd  = '0;
    if (!exp_err && !wen) begin
      if (w == 2'd0) begin
        v = (mmem[idx] >> (8 * lo)) & 32'hFF;
        if (!uns && v >= 32'h80) v = v - 32'h100;
      end else if (w == 2'd1) begin
        v = (mmem[idx] >> (16 * (lo / 2))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end else begin
        v = mmem[idx];
      end
      exp_rd = v;
    end
    if (!exp_err && wen) begin
      sh   = 8 * lo;
      mask = (w == 2'd0) ? (32'hFF << sh) : (w == 2'd1) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
      mmem[idx] = (mmem[idx] & ~mask) | ((wdata << sh) & mask);
    end

    ready_seen = 1'b0;
    for (int i = 0; i < 40 && !ready_seen; i++) begin
      if (cpu_req_ready) ready_seen = 1'b1;
      else @(negedge clk);
    end
    if (!ready_seen) check("ready_wait", {31'd0, cpu_req_ready}, 32'd1);
    cpu_req_valid = 1'b1;
    cpu_wen       = wen;
    cpu_addr      = addr;
    cpu_width     = minibus_width_t'(w);
    cpu_unsigned  = uns;
    cpu_wdata     = wdata;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;

    busy = 0;
    got  = 1'b0;
    rd_o = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (mif.req.wen || mif.req.ren) busy++;
      if (k == 0 && !misal) begin
        check("req_wen",   {31'd0, mif.req.wen}, {31'd0, wen});
        check("req_ren",   {31'd0, mif.req.ren}, {31'd0, !wen});
        check("req_addr",  mif.req.addr, addr);
        check("req_width", 32'(mif.req.width), 32'(w));
        check("req_wdata", mif.req.wdata, wdata);
      end
      if (cpu_resp_valid) begin
        got  = 1'b1;
        rd_o = cpu_rdata;
        check("latency", k, exp_lat);
        check("rdata", cpu_rdata, exp_rd);
        check("err", {31'd0, cpu_err}, {31'd0, exp_err});
        check("ready_in_turn", {31'd0, cpu_req_ready}, 32'd0);
        check("busy_cycles", busy, exp_lat);
        check("req_dropped", {31'd0, mif.req.wen | mif.req.ren}, 32'd0);
        if (no_ack && !misal) check("req_cleared", mif.req.addr, 32'd0);
      end
    end
    if (!got) check("resp_seen", 32'd0, 32'd1);
    @(negedge clk);
    check("ready_back", {31'd0, cpu_req_ready}, 32'd1);
    check("resp_pulse", {31'd0, cpu_resp_valid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic [1:0]  w;
    logic        wen, uns;
    int unsigned r;

    for (int i = 0; i < 64; i++) begin
      smem[i] = $urandom;
      mmem[i] = smem[i];
    end
    smem[1] = 32'hDEADBEEF;
    mmem[1] = 32'hDEADBEEF;

    // Reset values while nrst is held low across clock edges.
    #22;
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("rst_resp",  {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err",   {31'd0, cpu_err}, 32'd0);
    check("rst_req",   {31'd0, mif.req.wen | mif.req.ren}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, cpu_req_ready}, 32'd1);

    // Directed cases from the block's intended use.
    slv_delay = 0;
    do_access(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, rd);
    check("word_load", rd, 32'hDEADBEEF);
    do_access(1'b0, 32'h7, 2'd0, 1'b0, 32'h0, rd);
    check("byte_signed", rd, 32'hFFFFFFDE);
    do_access(1'b0, 32'h7, 2'd0, 1'b1, 32'h0, rd);
    check("byte_unsigned", rd, 32'h000000DE);
    do_access(1'b0, 32'h6, 2'd1, 1'b0, 32'h0, rd);
    check("half_signed", rd, 32'hFFFFDEAD);
    do_access(1'b1, 32'h3, 2'd1, 1'b0, 32'hCAFE, rd);
    do_access(1'b0, 32'h400, 2'd2, 1'b0, 32'h0, rd);
    do_access(1'b1, 32'h0, 2'd2, 1'b0, 32'h12345678, rd);
    do_access(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd);
    check("readback", rd, 32'h12345678);

    // Reset while a transaction waits in BUS.
    cpu_req_valid = 1'b1;
    cpu_wen       = 1'b0;
    cpu_addr      = 32'h800;
    cpu_width     = WORD;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bus_before_rst", {31'd0, mif.req.ren}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("arst_ren",   {31'd0, mif.req.ren}, 32'd0);
    check("arst_addr",  mif.req.addr, 32'd0);
    check("arst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("arst_resp",  {31'd0, cpu_resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) check("no_resp_after_rst", 32'd1, 32'd0);
    end
    do_access(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd);
    check("after_rst_load", rd, 32'h12345678);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      slv_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 8)       a = $urandom_range(0, 32'hFF);
      else if (r == 8) a = 32'h100 + $urandom_range(0, 32'hFF);
      else             a = 32'h400 + $urandom_range(0, 32'hFFF);
      w   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (($urandom_range(0, 1) == 0) && w != 2'd3) a = a & ~((32'd1 << w) - 32'd1);
      wen = ($urandom_range(0, 9) < 3);
      uns = $urandom_range(0, 1);
      wd  = $urandom;
      do_access(wen, a, w, uns, wd, rd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
